fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one `fifo` write port among `NUM_REQ` producers. Each producer requests bursts of up to `MAX_BURST` words. The arbiter grants one producer at a time and muxes its data onto the FIFO write port. Writes are gated by the FIFO `full_o` flag, so no word is lost or duplicated. It sits directly in front of the FIFO instance in the Lease Cache test harness.

---
 rtl/fifo_arb_pkg.sv | 29 ++
 rtl/rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Ceiling log2; clog2(1) == 0. Same helper as used by fifo.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Beat counter must hold 0..MAX_BURST.
  function automatic int unsigned beat_cnt_w(input int unsigned max_burst);
    return clog2(max_burst + 1);
  endfunction

  // Producer index width, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned num_req);
    return (num_req > 1) ? clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int unsigned    cand_int;
  logic [IW-1:0]  cand;

  // Scan lowest to highest priority so the nearest requester after ptr wins.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    cand_int = 0;
    cand     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand_int = 32'(ptr) + (N - k);
      if (cand_int >= N) cand_int = cand_int - N;
      cand = IW'(cand_int);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ-1:0]       last_i,
  input  logic [NUM_REQ*WIDTH-1:0] din_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       ack_o,
  input  logic                     fifo_full_i,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_din_o,
  output logic                     busy_o
);

  localparam int unsigned IW = idx_w(NUM_REQ);
  localparam int unsigned BW = beat_cnt_w(MAX_BURST);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] gnt_r;
  logic [IW-1:0]      rr_ptr;
  logic [BW-1:0]      beat_cnt;
  logic               busy_r;
  logic               accept;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic [WIDTH-1:0]   din_a [NUM_REQ];

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_slice
    assign din_a[n] = din_i[n*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req (req_i),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Write path: while in BURST, rr_ptr is the current owner's index.
  always_comb begin
    accept       = 1'b0;
    ack_o        = '0;
    fifo_wr_en_o = 1'b0;
    fifo_din_o   = '0;
    if (state_q == BURST) begin
      accept         = req_i[rr_ptr] & ~fifo_full_i;
      ack_o[rr_ptr]  = accept;
      fifo_wr_en_o   = accept;
      fifo_din_o     = din_a[rr_ptr];
    end
  end

  // Arbitration FSM: grant in IDLE, count beats and detect burst end in BURST.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      gnt_r    <= '0;
      rr_ptr   <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
      busy_r   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q  <= BURST;
            gnt_r    <= pick_gnt;
            rr_ptr   <= pick_idx;
            beat_cnt <= '0;
            busy_r   <= 1'b1;
          end else begin
            gnt_r <= '0;
          end
        end
        BURST: begin
          if (accept) beat_cnt <= beat_cnt + BW'(1);
          if (!req_i[rr_ptr] ||
              (accept && (last_i[rr_ptr] || beat_cnt == BW'(MAX_BURST - 1)))) begin
            state_q <= IDLE;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o  = gnt_r;
  assign busy_o = busy_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: behavioural model, scoreboard, directed tests, random run.
module tb_fifo_wr_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  logic           clk_i   = 1'b0;
  logic           reset_i = 1'b1;
  logic [N-1:0]   req_i   = '0;
  logic [N-1:0]   last_i  = '0;
  logic [N*W-1:0] din_i   = '0;
  logic           fifo_full_i = 1'b0;
  logic [N-1:0]   gnt_o, ack_o;
  logic           fifo_wr_en_o, busy_o;
  logic [W-1:0]   fifo_din_o;

  always #5 clk_i = ~clk_i;

  fifo_wr_arbiter #(
    .WIDTH     (W),
    .NUM_REQ   (N),
    .MAX_BURST (MB)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_i        (req_i),
    .last_i       (last_i),
    .din_i        (din_i),
    .gnt_o        (gnt_o),
    .ack_o        (ack_o),
    .fifo_full_i  (fifo_full_i),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_din_o   (fifo_din_o),
    .busy_o       (busy_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int prod_cnt [N];
  int sb_cnt   [N];
  int wr_per   [N];
  int wr_total = 0;
  logic [W-1:0] last_wr = '0;
  logic [N-1:0] ack_q   = '0;

  // Model state: who owns the port (-1 = nobody), last owner, words taken this burst.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_beats = 0;
  int m_c;
  logic m_acc;

  logic [N-1:0] e_gnt, e_ack;
  logic         e_acc;
  logic [W-1:0] e_din;

  function automatic logic [W-1:0] data_of(input int n, input int c);
    return W'((n << 6) | (c & 63));
  endfunction

  function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endfunction

  // Model update on each edge: arbitrate round-robin, or advance/close the burst.
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      m_owner = -1;
      m_last  = N - 1;
      m_beats = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        m_c = (m_last + k) % N;
        if (m_owner < 0 && req_i[m_c]) begin
          m_owner = m_c;
          m_last  = m_c;
          m_beats = 0;
        end
      end
    end else begin
      m_acc = req_i[m_owner] && !fifo_full_i;
      if (m_acc) m_beats++;
      if (!req_i[m_owner] || (m_acc && (last_i[m_owner] || m_beats == MB))) m_owner = -1;
    end
  end

  // Compare every cycle at the falling edge, plus per-producer order scoreboard.
  always @(negedge clk_i) begin
    if (reset_i) begin
      for (int n = 0; n < N; n++) begin
        sb_cnt[n] = 0;
        wr_per[n] = 0;
      end
      wr_total = 0;
      ack_q    = '0;
    end else begin
      e_gnt = '0;
      e_ack = '0;
      e_acc = 1'b0;
      e_din = '0;
      if (m_owner >= 0) begin
        e_gnt[m_owner] = 1'b1;
        e_acc          = req_i[m_owner] && !fifo_full_i;
        e_ack[m_owner] = e_acc;
        e_din          = din_i[m_owner*W +: W];
      end
      check("gnt_o",        32'(gnt_o),        32'(e_gnt));
      check("ack_o",        32'(ack_o),        32'(e_ack));
      check("fifo_wr_en_o", 32'(fifo_wr_en_o), 32'(e_acc));
      check("fifo_din_o",   32'(fifo_din_o),   32'(e_din));
      check("busy_o",       32'(busy_o),       32'(m_owner >= 0));
      if (e_acc) begin
        check("sb_word_order", 32'(fifo_din_o), 32'(data_of(m_owner, sb_cnt[m_owner])));
        sb_cnt[m_owner]++;
      end
      if (fifo_wr_en_o) begin
        wr_total++;
        last_wr = fifo_din_o;
      end
      for (int n = 0; n < N; n++) wr_per[n] += int'(ack_o[n]);
      ack_q = ack_o;
    end
  end

  task automatic drive_din();
    for (int n = 0; n < N; n++) din_i[n*W +: W] = data_of(n, prod_cnt[n]);
  endtask

  // Advance one clock; producers present their next word after an ack.
  task automatic tick();
    @(posedge clk_i);
    #1;
    for (int n = 0; n < N; n++) if (ack_q[n]) prod_cnt[n]++;
    drive_din();
  endtask

  // Assert reset (checking outputs drop immediately), clear stimulus, release.
  task automatic do_reset();
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    #1;
    check("rst_gnt",   32'(gnt_o),        32'h0);
    check("rst_ack",   32'(ack_o),        32'h0);
    check("rst_wr_en", 32'(fifo_wr_en_o), 32'h0);
    check("rst_din",   32'(fifo_din_o),   32'h0);
    check("rst_busy",  32'(busy_o),       32'h0);
    req_i       = '0;
    last_i      = '0;
    fifo_full_i = 1'b0;
    for (int n = 0; n < N; n++) prod_cnt[n] = 0;
    drive_din();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < N; n++) prod_cnt[n] = 0;
    drive_din();
    repeat (2) @(posedge clk_i);

    // T1: two requesters, no last: producer 0 gets a full 4-word burst, then 2.
    do_reset();
    req_i = 4'b0101;
    tick();                       // cycle 1
    check("t1_gnt_c1", 32'(gnt_o), 32'b0001);
    repeat (4) tick();            // cycle 5
    check("t1_gnt_c5", 32'(gnt_o), 32'b0000);
    check("t1_writes", 32'(wr_total), 32'd4);
    check("t1_last_word", 32'(last_wr), 32'h03);
    tick();                       // cycle 6
    check("t1_gnt_c6", 32'(gnt_o), 32'b0100);

    // T2: all requesting, last on every word: 0,1,2,3,0 with one idle cycle between.
    do_reset();
    req_i  = 4'b1111;
    last_i = 4'b1111;
    tick(); check("t2_gnt_c1", 32'(gnt_o), 32'b0001);
    tick(); check("t2_gnt_c2", 32'(gnt_o), 32'b0000);
    tick(); check("t2_gnt_c3", 32'(gnt_o), 32'b0010);
    tick(); tick(); check("t2_gnt_c5", 32'(gnt_o), 32'b0100);
    tick(); tick(); check("t2_gnt_c7", 32'(gnt_o), 32'b1000);
    tick(); tick(); check("t2_gnt_c9", 32'(gnt_o), 32'b0001);
    for (int n = 0; n < N; n++) check("t2_one_write_each", 32'(wr_per[n]), 32'd1);

    // T3: FIFO full for 3 cycles at beat 2; grant held, nothing written meanwhile.
    do_reset();
    req_i = 4'b0001;
    tick(); tick(); tick();       // cycle 3
    fifo_full_i = 1'b1;
    #1;
    check("t3_stall_wr_en", 32'(fifo_wr_en_o), 32'h0);
    check("t3_stall_ack",   32'(ack_o),        32'h0);
    check("t3_stall_gnt",   32'(gnt_o),        32'b0001);
    tick(); tick(); tick();       // cycle 6
    fifo_full_i = 1'b0;
    check("t3_writes_before_release", 32'(wr_total), 32'd2);
    check("t3_gnt_held", 32'(gnt_o), 32'b0001);
    tick(); tick();               // cycle 8
    check("t3_gnt_c8", 32'(gnt_o), 32'b0000);
    check("t3_writes", 32'(wr_total), 32'd4);
    check("t3_last_word", 32'(last_wr), 32'h03);
    req_i = '0;

    // T4: owner abandons after one beat; next requester takes over.
    do_reset();
    req_i = 4'b0011;
    tick();                       // cycle 1
    check("t4_gnt_c1", 32'(gnt_o), 32'b0001);
    tick();                       // cycle 2
    req_i[0] = 1'b0;
    tick();                       // cycle 3
    check("t4_gnt_c3", 32'(gnt_o), 32'b0000);
    check("t4_writes", 32'(wr_total), 32'd1);
    tick();                       // cycle 4
    check("t4_gnt_c4", 32'(gnt_o), 32'b0010);

    // T5: reset mid-burst at beat 1; afterwards requester 0 wins first again.
    do_reset();
    req_i = 4'b0011;
    tick(); tick();               // cycle 2, beat 1 pending
    do_reset();
    req_i = 4'b0011;
    tick();
    check("t5_gnt_after_reset", 32'(gnt_o), 32'b0001);

    // Random run: producers hold words until acked, occasionally abandon.
    do_reset();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      tick();
      for (int n = 0; n < N; n++) begin
        if (req_i[n]) begin
          if (ack_q[n]) begin
            req_i[n]  = ($urandom % 4) != 0;
            last_i[n] = ($urandom % 4) == 0;
          end else if (($urandom % 50) == 0) begin
            req_i[n] = 1'b0;
          end
        end else if (($urandom % 2) != 0) begin
          req_i[n]  = 1'b1;
          last_i[n] = ($urandom % 4) == 0;
        end
      end
      fifo_full_i = ($urandom % 5) == 0;
    end
    tick();
    req_i = '0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
